spi_serdes: RTL and testbench
=============================

// Module: spi_serdes
// PURPOSE
//   Bit-level SPI target engine between the input synchronizers and the SPI register wrapper.
//   Inputs: synchronized cs_n/sclk/mosi and the mode pins. Outputs: assembled MOSI bytes as rx
//   strobes. Serializes wrapper-supplied tx bytes onto MISO.
//   Supports all four SPI modes. MSB first, 8-bit words, any number of bytes per CS frame.
// PARAMETERS
//   None. Word width fixed at 8.
// PORTS
//   clk           in   1  system clock; all logic on rising edge
//   rst           in   1  asynchronous, active-high reset
//   ena           in   1  clock enable; when low every register holds
//   mode          in   2  {cpol,cpha}, synchronized; captured at frame start
//   spi_cs_n      in   1  synchronized chip select, active low
//   spi_clk       in   1  synchronized SPI clock
//   spi_mosi      in   1  synchronized MOSI
//   spi_miso      out  1  MISO bit, registered
//   tx_data       in   8  next byte to send; sampled in the cycle tx_taken=1
//   tx_taken      out  1  1-cycle pulse: tx_data loaded into tx shifter
//   rx_data       out  8  last complete received byte; held until next byte
//   rx_valid      out  1  1-cycle pulse: rx_data updated this cycle
//   rx_first      out  1  with rx_valid: byte is first of current frame
//   frame_active  out  1  high between CS fall and CS rise
// BEHAVIOUR
//   - Reset: all outputs 0; bit_cnt=0; sampled=0; internal history regs: cs_d=1, clk_d=0.
//   - Edge detection: rise=spi_clk&~clk_d, fall=~spi_clk&clk_d.
//     cs_fall=~spi_cs_n&cs_d, cs_rise=spi_cs_n&~cs_d.
//   - mode_q<=mode on cs_fall. leading=cpol?fall:rise, trailing=cpol?rise:fall.
//     sample_edge=cpha?trailing:leading, shift_edge=cpha?leading:trailing.
//   - cs_fall:
//     - frame_active<=1, bit_cnt<=0, sampled<=0, first flag<=1.
//     - tx_shift<=tx_data, tx_taken pulse, spi_miso<=tx_data[7].
//   - sample_edge while frame active:
//     - rx_shift<={rx_shift[6:0],spi_mosi}, sampled<=1, bit_cnt<=bit_cnt+1.
//     - If bit_cnt==7: rx_data<={rx_shift[6:0],spi_mosi}, rx_valid=1, rx_first=first flag.
//       first flag<=0, bit_cnt wraps to 0, reload pending<=1.
//   - shift_edge while frame active and sampled==1:
//     - If reload pending: tx_shift<=tx_data, tx_taken pulse, spi_miso<=tx_data[7],
//       reload pending<=0.
//     - Else tx_shift<<=1 and spi_miso<=tx_shift[6].
//     - sampled gating suppresses the first leading edge in cpha=1.
//   - Latency: rx_valid asserts 1 clk after the sample edge of bit 7 is seen on spi_clk.
//     Synchronizer delay is excluded.
//   - cs_rise:
//     - frame_active<=0, bit_cnt<=0, spi_miso<=0.
//     - A partial byte is discarded; no rx_valid.
//     - cs_rise wins over a coincident SPI clock edge.
//   - cs_n high: all spi_clk edges ignored; spi_miso held 0.
//   - mode change mid-frame: ignored until next cs_fall.
//   - Reset mid-frame: immediate return to reset values. The next transfer requires a fresh
//     cs_fall; if cs_n is still low after reset, the engine is idle until CS rises and falls.
//   - Upstream must present the next tx_data within one byte time of rx_valid.
// CONFIGURATION
//   SPI_FRAME_ERR_EN defined: adds output frame_err (1 bit, reset 0).
//     - frame_err pulses 1 cycle on cs_rise when bit_cnt!=0, i.e. a partial byte.
//   SPI_FRAME_ERR_EN undefined: port frame_err absent; partial bytes silently dropped.
// TESTING
//   - Mode 0, tx_data=0x3C, MOSI 0xA5, 8 clocks:
//     rx_data=0xA5, rx_valid x1, rx_first=1; MISO bits 0,0,1,1,1,1,0,0.
//   - Mode 3, two bytes 0x12,0x34, tx_data 0x80 then 0x01:
//     rx_valid x2, rx_first 1 then 0; MISO 0x80,0x01; tx_taken x2.
//   - Mode 1 and mode 2, MOSI 0xC3: rx_data=0xC3, and no shift on the first leading edge.
//   - CS high after 5 bits of 0xFF: no rx_valid, frame_active=0, spi_miso=0.
//     With SPI_FRAME_ERR_EN, frame_err pulses once.
//   - Assert rst after bit 4, release, clock 8 bits with CS held low:
//     no rx_valid; a fresh CS frame of 0x5A gives rx_data=0x5A.
//   - Toggle spi_clk with cs_n high, and hold ena=0 mid-frame: no state change, no strobes.

Source files
------------

// File: rtl/spi_serdes.sv
// Bit-level SPI target engine: deserializes MOSI into bytes, serializes tx bytes onto MISO, all four modes.
// Optional frame_err output is compiled in with `define SPI_FRAME_ERR_EN.
module spi_serdes (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [1:0] mode,
    input  logic       spi_cs_n,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic [7:0] tx_data,
    output logic       tx_taken,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       frame_active
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic       frame_err
`endif
);

    logic       cs_d;
    logic       clk_d;
    logic       cs_armed;
    logic [1:0] mode_q;
    logic [2:0] bit_cnt;
    logic       sampled;
    logic       first_flag;
    logic       reload_pending;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;

    logic rise;
    logic fall;
    logic cs_fall;
    logic cs_rise;
    logic leading;
    logic trailing;
    logic sample_edge;
    logic shift_edge;

    // Edge decode; cs_armed keeps a CS already low at reset release from opening a frame.
    always_comb begin
        rise        = spi_clk & ~clk_d;
        fall        = ~spi_clk & clk_d;
        cs_fall     = ~spi_cs_n & cs_d & cs_armed;
        cs_rise     = spi_cs_n & ~cs_d;
        leading     = mode_q[1] ? fall : rise;
        trailing    = mode_q[1] ? rise : fall;
        sample_edge = frame_active & (mode_q[0] ? trailing : leading);
        shift_edge  = frame_active & sampled & (mode_q[0] ? leading : trailing);
    end

    // Frame control, rx deserializer and tx serializer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_d           <= 1'b1;
            clk_d          <= 1'b0;
            cs_armed       <= 1'b0;
            mode_q         <= 2'b00;
            bit_cnt        <= 3'd0;
            sampled        <= 1'b0;
            first_flag     <= 1'b0;
            reload_pending <= 1'b0;
            tx_shift       <= 8'h00;
            rx_shift       <= 8'h00;
            spi_miso       <= 1'b0;
            tx_taken       <= 1'b0;
            rx_data        <= 8'h00;
            rx_valid       <= 1'b0;
            rx_first       <= 1'b0;
            frame_active   <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err      <= 1'b0;
`endif
        end else begin
            tx_taken  <= 1'b0;
            rx_valid  <= 1'b0;
            rx_first  <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
            if (ena) begin
                cs_d  <= spi_cs_n;
                clk_d <= spi_clk;
                if (spi_cs_n) begin
                    cs_armed <= 1'b1;
                end
                if (cs_rise) begin
                    frame_active   <= 1'b0;
                    bit_cnt        <= 3'd0;
                    spi_miso       <= 1'b0;
                    reload_pending <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
                    frame_err      <= frame_active & (bit_cnt != 3'd0);
`endif
                end else if (cs_fall) begin
                    mode_q         <= mode;
                    frame_active   <= 1'b1;
                    bit_cnt        <= 3'd0;
                    sampled        <= 1'b0;
                    first_flag     <= 1'b1;
                    reload_pending <= 1'b0;
                    tx_shift       <= tx_data;
                    tx_taken       <= 1'b1;
                    spi_miso       <= tx_data[7];
                end else begin
                    if (sample_edge) begin
                        rx_shift <= {rx_shift[6:0], spi_mosi};
                        sampled  <= 1'b1;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data        <= {rx_shift[6:0], spi_mosi};
                            rx_valid       <= 1'b1;
                            rx_first       <= first_flag;
                            first_flag     <= 1'b0;
                            reload_pending <= 1'b1;
                        end
                    end
                    // A completed byte defers the next tx load to the following shift edge.
                    if (shift_edge) begin
                        if (reload_pending) begin
                            tx_shift       <= tx_data;
                            tx_taken       <= 1'b1;
                            spi_miso       <= tx_data[7];
                            reload_pending <= 1'b0;
                        end else begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            spi_miso <= tx_shift[6];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_serdes.sv
// Randomized and directed bench for spi_serdes against a frame-level behavioural model.
module tb_spi_serdes;

    localparam int HALF = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [1:0] mode;
    logic       spi_cs_n;
    logic       spi_clk;
    logic       spi_mosi;
    logic       spi_miso;
    logic [7:0] tx_data;
    logic       tx_taken;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic       frame_active;
`ifdef SPI_FRAME_ERR_EN
    logic       frame_err;
`endif

    spi_serdes dut (
        .clk(clk), .rst(rst), .ena(ena), .mode(mode),
        .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .tx_data(tx_data), .tx_taken(tx_taken), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_first(rx_first), .frame_active(frame_active)
`ifdef SPI_FRAME_ERR_EN
        , .frame_err(frame_err)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cnt_rxv = 0, cnt_first = 0, cnt_take = 0, cnt_ferr = 0;
    logic [7:0] tx_plan[$];
    bit ena_jitter = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: counts sampled bits and effective shift edges per frame.
    logic       m_pcs, m_pclk, m_armed, m_in;
    logic [1:0] m_mode;
    int         m_nsamp, m_nshift, m_acc;
    logic [7:0] m_txq[$];
    logic       e_miso, e_taken, e_rxv, e_first, e_active, e_ferr;
    logic [7:0] e_rx_data;

    always @(posedge clk) begin
        bit csr, csf, r, f, on_rise, smp, shf;
        logic [7:0] cur;
        if (rst) begin
            m_pcs = 1'b1; m_pclk = 1'b0; m_armed = 1'b0; m_in = 1'b0; m_mode = 2'd0;
            m_nsamp = 0; m_nshift = 0; m_acc = 0; m_txq.delete();
            e_miso = 1'b0; e_taken = 1'b0; e_rxv = 1'b0; e_first = 1'b0;
            e_active = 1'b0; e_ferr = 1'b0; e_rx_data = 8'h00;
        end else begin
            e_taken = 1'b0; e_rxv = 1'b0; e_first = 1'b0; e_ferr = 1'b0;
            if (ena) begin
                csr = spi_cs_n && !m_pcs;
                csf = !spi_cs_n && m_pcs && m_armed;
                r   = spi_clk && !m_pclk;
                f   = !spi_clk && m_pclk;
                if (csr) begin
                    e_ferr = m_in && (m_nsamp % 8 != 0);
                    m_in = 1'b0; e_active = 1'b0; e_miso = 1'b0;
                end else if (csf) begin
                    m_in = 1'b1; e_active = 1'b1; m_mode = mode;
                    m_nsamp = 0; m_nshift = 0; m_acc = 0;
                    m_txq.delete(); m_txq.push_back(tx_data);
                    e_taken = 1'b1; e_miso = tx_data[7];
                end else if (m_in) begin
                    on_rise = (m_mode == 2'd0) || (m_mode == 2'd3);
                    smp = on_rise ? r : f;
                    shf = on_rise ? f : r;
                    if (smp) begin
                        m_acc = (m_acc * 2 + int'(spi_mosi)) % 256;
                        m_nsamp++;
                        if (m_nsamp % 8 == 0) begin
                            e_rx_data = 8'(m_acc); e_rxv = 1'b1; e_first = (m_nsamp == 8);
                        end
                    end
                    if (shf && m_nsamp > 0) begin
                        m_nshift++;
                        if (m_nshift % 8 == 0) begin
                            m_txq.push_back(tx_data); e_taken = 1'b1; e_miso = tx_data[7];
                        end else begin
                            cur = m_txq[m_nshift / 8];
                            e_miso = cur[7 - (m_nshift % 8)];
                        end
                    end
                end
                if (spi_cs_n) m_armed = 1'b1;
                m_pcs = spi_cs_n; m_pclk = spi_clk;
            end
        end
    end

    // Per-cycle compare against the model, plus pulse counters.
    initial begin
        forever begin
            @(negedge clk); #1;
            if (rst) begin
                chk("rst_miso", spi_miso, 0); chk("rst_taken", tx_taken, 0);
                chk("rst_rx_data", rx_data, 0); chk("rst_rx_valid", rx_valid, 0);
                chk("rst_rx_first", rx_first, 0); chk("rst_active", frame_active, 0);
            end else begin
                chk("miso", spi_miso, e_miso); chk("tx_taken", tx_taken, e_taken);
                chk("rx_data", rx_data, e_rx_data); chk("rx_valid", rx_valid, e_rxv);
                chk("rx_first", rx_first, e_first); chk("frame_active", frame_active, e_active);
`ifdef SPI_FRAME_ERR_EN
                chk("frame_err", frame_err, e_ferr);
`endif
            end
            if (rx_valid === 1'b1) cnt_rxv++;
            if (rx_valid === 1'b1 && rx_first === 1'b1) cnt_first++;
            if (tx_taken === 1'b1) cnt_take++;
`ifdef SPI_FRAME_ERR_EN
            if (frame_err === 1'b1) cnt_ferr++;
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
        if (tx_taken === 1'b1) tx_data = (tx_plan.size() > 0) ? tx_plan.pop_front() : 8'($urandom);
        if (ena_jitter) ena = ($urandom_range(0, 5) != 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic frame_begin(input logic [1:0] m, input logic [7:0] tx);
        spi_cs_n = 1'b1; mode = m; spi_clk = m[1];
        ticks(3);
        tx_data = tx; spi_cs_n = 1'b0;
        ticks(HALF);
    endtask

    task automatic frame_end();
        ticks(HALF);
        spi_cs_n = 1'b1;
        ticks(HALF);
    endtask

    // Master side: drives n bits MSB-first from mv[63], captures MISO just before each sample edge.
    task automatic clock_bits(input logic [1:0] m, input int n, input logic [63:0] mv,
                              output logic [63:0] cap);
        cap = 64'h0;
        for (int i = 0; i < n; i++) begin
            if (m[0] == 1'b0) begin
                spi_mosi = mv[63 - i]; ticks(HALF);
                cap[63 - i] = spi_miso;
                spi_clk = ~m[1]; ticks(HALF);
                spi_clk = m[1]; ticks(HALF);
            end else begin
                spi_clk = ~m[1]; ticks(HALF);
                spi_mosi = mv[63 - i]; ticks(HALF);
                cap[63 - i] = spi_miso;
                spi_clk = m[1]; ticks(HALF);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] cap;
        int b_rxv, b_first, b_take, b_ferr, nb;
        logic [1:0] rm;
        rst = 1'b1; ena = 1'b1; mode = 2'd0; spi_cs_n = 1'b1; spi_clk = 1'b0;
        spi_mosi = 1'b0; tx_data = 8'h00;
        ticks(3);
        chk("reset_active", frame_active, 0); chk("reset_miso", spi_miso, 0);
        rst = 1'b0;
        ticks(2);

        // Mode 0, tx 0x3C, MOSI 0xA5
        b_rxv = cnt_rxv; b_first = cnt_first;
        frame_begin(2'd0, 8'h3C);
        clock_bits(2'd0, 8, {8'hA5, 56'h0}, cap);
        frame_end();
        chk("m0_rx_data", rx_data, 8'hA5); chk("m0_model_rx", e_rx_data, 8'hA5);
        chk("m0_rxv_count", cnt_rxv - b_rxv, 1); chk("m0_first_count", cnt_first - b_first, 1);
        chk("m0_miso", cap[63:56], 8'h3C);

        // Mode 3, two bytes
        b_rxv = cnt_rxv; b_first = cnt_first; b_take = cnt_take;
        tx_plan.push_back(8'h01);
        frame_begin(2'd3, 8'h80);
        clock_bits(2'd3, 16, {16'h1234, 48'h0}, cap);
        frame_end();
        chk("m3_rx_data", rx_data, 8'h34); chk("m3_rxv_count", cnt_rxv - b_rxv, 2);
        chk("m3_first_count", cnt_first - b_first, 1); chk("m3_take_count", cnt_take - b_take, 2);
        chk("m3_miso", cap[63:48], 16'h8001);

        // Modes 1 and 2, MOSI 0xC3
        frame_begin(2'd1, 8'h96);
        clock_bits(2'd1, 8, {8'hC3, 56'h0}, cap);
        frame_end();
        chk("m1_rx_data", rx_data, 8'hC3); chk("m1_miso", cap[63:56], 8'h96);
        frame_begin(2'd2, 8'h69);
        clock_bits(2'd2, 8, {8'hC3, 56'h0}, cap);
        frame_end();
        chk("m2_rx_data", rx_data, 8'hC3); chk("m2_miso", cap[63:56], 8'h69);

        // Partial byte: 5 bits of 0xFF
        b_rxv = cnt_rxv; b_ferr = cnt_ferr;
        frame_begin(2'd0, 8'hF0);
        clock_bits(2'd0, 5, {8'hFF, 56'h0}, cap);
        frame_end();
        chk("part_rxv_count", cnt_rxv - b_rxv, 0); chk("part_active", frame_active, 0);
        chk("part_miso", spi_miso, 0); chk("part_rx_data", rx_data, 8'hC3);
`ifdef SPI_FRAME_ERR_EN
        chk("part_ferr_count", cnt_ferr - b_ferr, 1);
`endif

        // Reset mid-frame, CS held low
        frame_begin(2'd0, 8'h11);
        clock_bits(2'd0, 4, {8'hF0, 56'h0}, cap);
        rst = 1'b1; ticks(2); rst = 1'b0; tick();
        b_rxv = cnt_rxv;
        clock_bits(2'd0, 8, {8'hFF, 56'h0}, cap);
        chk("rstmid_rxv_count", cnt_rxv - b_rxv, 0); chk("rstmid_active", frame_active, 0);
        frame_end();
        frame_begin(2'd0, 8'h22);
        clock_bits(2'd0, 8, {8'h5A, 56'h0}, cap);
        frame_end();
        chk("rstmid_fresh_rx", rx_data, 8'h5A);

        // spi_clk toggling with CS high
        b_rxv = cnt_rxv; b_take = cnt_take;
        for (int i = 0; i < 10; i++) begin spi_clk = ~spi_clk; spi_mosi = ~spi_mosi; ticks(HALF); end
        chk("csh_rxv_count", cnt_rxv - b_rxv, 0); chk("csh_take_count", cnt_take - b_take, 0);
        chk("csh_active", frame_active, 0); chk("csh_miso", spi_miso, 0);

        // ena low mid-frame freezes the engine
        frame_begin(2'd0, 8'h00);
        clock_bits(2'd0, 3, {8'hB4, 56'h0}, cap);
        ena = 1'b0;
        b_rxv = cnt_rxv; b_take = cnt_take;
        for (int i = 0; i < 4; i++) begin spi_clk = ~spi_clk; spi_mosi = ~spi_mosi; ticks(HALF); end
        chk("ena_rxv_count", cnt_rxv - b_rxv, 0); chk("ena_take_count", cnt_take - b_take, 0);
        chk("ena_active", frame_active, 1);
        ena = 1'b1;
        clock_bits(2'd0, 5, {8'hB4 << 3, 56'h0}, cap);
        frame_end();
        chk("ena_rx_data", rx_data, 8'hB4);

        // Randomized frames with ena jitter and mid-frame mode changes
        ena_jitter = 1'b1;
        for (int k = 0; k < 40; k++) begin
            rm = 2'($urandom_range(0, 3));
            nb = $urandom_range(1, 24);
            frame_begin(rm, 8'($urandom));
            if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
            clock_bits(rm, nb, {$urandom, $urandom}, cap);
            frame_end();
        end
        ena_jitter = 1'b0; ena = 1'b1;
        ticks(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
